// File: rtl/alu_shift_pipe_if.sv
// Operand-issue / result-writeback bus for alu_shift_pipe.
// The slave modport is the datapath's view; master is the view of the block driving it.
interface alu_shift_pipe_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  // issue side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       S;
  logic             Cin;
  logic [1:0]       H;
  logic [SHW-1:0]   shamt;
  // writeback side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] O;
  logic             Cout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport slave (
    input  in_valid, A, B, S, Cin, H, shamt, out_ready,
    output in_ready, out_valid, O, Cout, zero, neg, ovf
  );

  modport master (
    output in_valid, A, B, S, Cin, H, shamt, out_ready,
    input  in_ready, out_valid, O, Cout, zero, neg, ovf
  );
endinterface

// File: rtl/alu_shift_pipe.sv
// Two-stage ALU + barrel shifter with valid/ready on both sides.
// Stage 1 registers the ALU result, carry and overflow; stage 2 registers the
// shifted result with zero/neg flags. Full throughput under a skid-free
// pipeline-advance scheme: a stage loads whenever it is empty or its
// downstream is advancing.
module alu_shift_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input logic              clk,
  input logic              reset,
  alu_shift_pipe_if.slave  bus
);

  generate
    if ((2 ** SHW) != WIDTH) begin : g_bad_shw
      $error("alu_shift_pipe: 2**SHW must equal WIDTH");
    end
    if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
      $error("alu_shift_pipe: WIDTH must be a power of two >= 4");
    end
  endgenerate

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // pipeline control
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  // stage 1 registers
  logic [WIDTH-1:0] s1_r;
  logic             s1_c;
  logic             s1_v;
  logic [1:0]       s1_h;
  logic [SHW-1:0]   s1_sh;

  // stage 2 registers
  logic [WIDTH-1:0] s2_o;
  logic             s2_c;
  logic             s2_v;
  logic             s2_z;
  logic             s2_n;

  // ALU combinational results
  logic [WIDTH:0]   alu_sum;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   cin_ext;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;

  // shifter combinational result
  logic [WIDTH-1:0] sh_o;

  // Advance conditions: each stage moves when it is empty or the next one moves.
  always_comb begin
    s2_adv = !s2_valid || bus.out_ready;
    s1_adv = !s1_valid || s2_adv;
  end

  assign bus.in_ready = s1_adv;

  // ALU: arithmetic in WIDTH+1 bits so the carry falls out as the top bit.
  always_comb begin
    a_ext   = {1'b0, bus.A};
    cin_ext = {{WIDTH{1'b0}}, bus.Cin};
    alu_sum = '0;
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.S)
      OP_ADD: begin
        alu_sum = a_ext + {1'b0, bus.B} + cin_ext;
        alu_r   = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (bus.A[MSB] == bus.B[MSB]) && (alu_r[MSB] != bus.A[MSB]);
      end
      OP_SUB: begin
        alu_sum = a_ext + {1'b0, ~bus.B} + cin_ext;
        alu_r   = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (bus.A[MSB] != bus.B[MSB]) && (alu_r[MSB] != bus.A[MSB]);
      end
      OP_AND:  alu_r = bus.A & bus.B;
      OP_OR:   alu_r = bus.A | bus.B;
      OP_XOR:  alu_r = bus.A ^ bus.B;
      OP_NOT:  alu_r = ~bus.A;
      OP_INC: begin
        alu_sum = a_ext + {{WIDTH{1'b0}}, 1'b1};
        alu_r   = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        // +1 is positive, so overflow only when a positive A wraps negative
        alu_v   = !bus.A[MSB] && alu_r[MSB];
      end
      OP_PASS: alu_r = bus.B;
      default: alu_r = '0;
    endcase
  end

  // Stage 1: capture ALU result and shift controls when the stage advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_c     <= 1'b0;
      s1_v     <= 1'b0;
      s1_h     <= '0;
      s1_sh    <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_r  <= alu_r;
        s1_c  <= alu_c;
        s1_v  <= alu_v;
        s1_h  <= bus.H;
        s1_sh <= bus.shamt;
      end
    end
  end

  // Barrel shifter on the stage-1 result.
  always_comb begin
    sh_o = s1_r;
    case (s1_h)
      SH_PASS: sh_o = s1_r;
      SH_LSL:  sh_o = s1_r << s1_sh;
      SH_LSR:  sh_o = s1_r >> s1_sh;
      SH_ASR:  sh_o = $signed(s1_r) >>> s1_sh;
      default: sh_o = s1_r;
    endcase
  end

  // Stage 2: capture shifted result and flags; holds while stalled downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_o     <= '0;
      s2_c     <= 1'b0;
      s2_v     <= 1'b0;
      s2_z     <= 1'b0;
      s2_n     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_o <= sh_o;
        s2_c <= s1_c;
        s2_v <= s1_v;
        s2_z <= (sh_o == '0);
        s2_n <= sh_o[MSB];
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.O         = s2_o;
  assign bus.Cout      = s2_c;
  assign bus.zero      = s2_z;
  assign bus.neg       = s2_n;
  assign bus.ovf       = s2_v;

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Scoreboard bench for alu_shift_pipe (WIDTH=8): the driver pushes expected
// results from an integer reference model; the monitor pops on each output beat.
module tb_alu_shift_pipe;

  localparam int W  = 8;
  localparam int SW = 3;

  typedef struct {
    int o;
    int c;
    int z;
    int n;
    int v;
    int acc;
    bit lat;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   npass;
  int   ntot;
  int   nacc;
  int   nout;
  bit   toggle_on;
  exp_t scb[$];

  alu_shift_pipe_if #(.WIDTH(W), .SHW(SW)) bus ();

  alu_shift_pipe #(.WIDTH(W), .SHW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  // Reference model: plain integer arithmetic on unsigned/signed values.
  function automatic exp_t model(input int a, input int b, input int s,
                                 input int cin, input int h, input int sh);
    exp_t e;
    int r, full, sa, sbv, ss, sr, o;
    int c, v;
    sa  = (a >= 128) ? a - 256 : a;
    sbv = (b >= 128) ? b - 256 : b;
    c = 0; v = 0; r = 0;
    case (s)
      0: begin full = a + b + cin; r = full % 256; c = (full >= 256);
               ss = sa + sbv + cin; v = (ss > 127) || (ss < -128); end
      1: begin full = a + (255 - b) + cin; r = full % 256; c = (full >= 256);
               ss = sa - sbv - 1 + cin; v = (ss > 127) || (ss < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin full = a + 1; r = full % 256; c = (full >= 256); v = (sa + 1 > 127); end
      default: r = b;
    endcase
    sr = (r >= 128) ? r - 256 : r;
    case (h)
      0: o = r;
      1: o = (r * (1 << sh)) % 256;
      2: o = r / (1 << sh);
      default: o = (sr >>> sh) & 255;
    endcase
    e.o = o; e.c = c; e.v = v;
    e.z = (o == 0);
    e.n = (o >= 128);
    e.acc = 0; e.lat = 1'b0;
    return e;
  endfunction

  // Present one beat; returns number of cycles the source had to hold it.
  task automatic send(input int a, input int b, input int s, input int cin,
                      input int h, input int sh, input bit lat, output int waited);
    exp_t e;
    bit   ok;
    int   av, bv;
    av = a; bv = b;
    bus.A = av[7:0]; bus.B = bv[7:0];
    bus.S = s[2:0]; bus.Cin = cin[0]; bus.H = h[1:0]; bus.shamt = sh[2:0];
    bus.in_valid = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited <= 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else waited++;
    end
    if (ok) begin
      e = model(a, b, s, cin, h, sh);
      e.acc = cyc;
      e.lat = lat;
      scb.push_back(e);
      nacc++;
    end else begin
      check("accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && scb.size() != 0; k++) @(posedge clk);
    check("drain_empty", scb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed output beat is compared against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      nout++;
      if (scb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = scb.pop_front();
        check("O", bus.O, e.o);
        check("flags{Cout,zero,neg,ovf}",
              {bus.Cout, bus.zero, bus.neg, bus.ovf},
              {e.c[0], e.z[0], e.n[0], e.v[0]});
        if (e.lat) check("latency", cyc - e.acc, 2);
      end
    end
  end

  // Random backpressure generator used in the mixed phase.
  always @(posedge clk) begin
    if (toggle_on) begin
      #1;
      if (toggle_on) bus.out_ready = ($urandom_range(3) != 0);
    end
  end

  initial begin
    int w, base, nbefore;
    npass = 0; ntot = 0; nacc = 0; nout = 0; cyc = 0; toggle_on = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.S = '0; bus.Cin = 1'b0; bus.H = '0; bus.shamt = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_O", bus.O, 0);
    check("rst_flags", {bus.Cout, bus.zero, bus.neg, bus.ovf}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed beats, no backpressure.
    bus.out_ready = 1'b1;
    send(8'hF0, 8'h20, 0, 0, 0, 0, 1'b0, w);
    send(8'h05, 8'h07, 1, 1, 0, 0, 1'b0, w);
    send(8'h7F, 8'h01, 0, 0, 0, 0, 1'b0, w);
    send(8'h80, 8'h00, 3, 0, 3, 3, 1'b0, w);
    send(8'h80, 8'h00, 3, 0, 2, 3, 1'b0, w);
    send(8'h80, 8'h00, 3, 0, 1, 1, 1'b0, w);
    send(8'h7F, 8'h00, 6, 1, 0, 0, 1'b0, w);
    send(8'hFF, 8'h00, 6, 0, 0, 0, 1'b0, w);
    send(8'h80, 8'h01, 1, 1, 0, 0, 1'b0, w);
    send(8'hA5, 8'h3C, 4, 1, 0, 0, 1'b0, w);
    send(8'h96, 8'h00, 5, 0, 3, 0, 1'b0, w);
    send(8'h93, 8'h00, 7, 0, 1, 0, 1'b0, w);
    send(8'h00, 8'hC3, 7, 0, 2, 0, 1'b0, w);
    send(8'hF0, 8'h3C, 2, 1, 3, 7, 1'b0, w);
    drain();

    // Continuous streaming: in_ready must stay high, latency exactly 2.
    for (int i = 0; i < 16; i++) begin
      send($urandom_range(255), $urandom_range(255), $urandom_range(7),
           $urandom_range(1), $urandom_range(3), $urandom_range(7), 1'b1, w);
      check("stream_in_ready", w, 0);
    end
    drain();

    // Backpressure: 4 back-to-back beats with the sink stalled.
    bus.out_ready = 1'b0;
    base = nacc;
    fork
      begin
        int ww;
        send(8'h11, 8'h22, 0, 0, 0, 0, 1'b0, ww);
        send(8'h33, 8'h44, 0, 1, 1, 2, 1'b0, ww);
        send(8'hC8, 8'h0F, 1, 1, 3, 1, 1'b0, ww);
        send(8'h5A, 8'hFF, 4, 0, 2, 4, 1'b0, ww);
      end
    join_none
    repeat (3) @(negedge clk);
    check("bp_accepted", nacc - base, 2);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_O", bus.O, (scb.size() > 0) ? scb[0].o : -1);
      check("bp_hold_accepted", nacc - base, 2);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && nacc - base < 4; k++) @(posedge clk);
    check("bp_all_accepted", nacc - base, 4);
    drain();

    // Mixed random traffic with random backpressure.
    toggle_on = 1'b1;
    for (int i = 0; i < 40; i++)
      send($urandom_range(255), $urandom_range(255), $urandom_range(7),
           $urandom_range(1), $urandom_range(3), $urandom_range(7), 1'b0, w);
    toggle_on = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    drain();

    // Asynchronous reset with two beats in flight.
    bus.out_ready = 1'b0;
    send(8'hF0, 8'h20, 0, 0, 0, 0, 1'b0, w);
    send(8'h7F, 8'h01, 0, 0, 0, 0, 1'b0, w);
    check("pre_rst_out_valid", bus.out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_O", bus.O, 0);
    check("mid_rst_flags", {bus.Cout, bus.zero, bus.neg, bus.ovf}, 0);
    scb.delete();
    #3 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    nbefore = nout;
    bus.out_ready = 1'b1;
    send(8'h0C, 8'h03, 3, 0, 1, 2, 1'b0, w);
    drain();
    repeat (5) @(posedge clk);
    check("post_rst_beats_out", nout - nbefore, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
